// File: rtl/noc_host_endpoint_if.sv
// Valid/ready flit channel used between the host endpoint and the router east port.
// The source holds valid and data stable until a cycle with valid && ready.
interface bus #(
  parameter int W = 32
) ();
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport source (output valid, output data, input ready);
  modport sink   (input valid, input data, output ready);
endinterface

// File: rtl/noc_host_endpoint.sv
// Host-side NoC endpoint: packs host requests into single-flit packets toward the router,
// buffers and filters returned flits for the host, and tracks request credit.
module noc_host_endpoint #(
  parameter  int NUM_ROUTER       = 20,
  parameter  int DATA_PACKET_SIZE = 32,
  parameter  int LOCAL_RANK       = 0,
  parameter  int FIFO_DEPTH       = 4,
  parameter  int MAX_OUTSTANDING  = 8,
  localparam int RW               = $clog2(NUM_ROUTER),
  localparam int PW               = DATA_PACKET_SIZE - RW - 5
) (
  input  logic          clk_rtr,
  input  logic          reset,
  bus.source            noc_src,
  bus.sink              noc_sink,
  input  logic          host_tx_valid,
  output logic          host_tx_ready,
  input  logic [RW-1:0] host_tx_dest,
  input  logic [PW-1:0] host_tx_payload,
  output logic          host_rx_valid,
  input  logic          host_rx_ready,
  output logic [PW-1:0] host_rx_payload,
  output logic [3:0]    host_rx_seq,
  output logic          host_rx_resp,
  output logic [7:0]    outstanding,
  output logic [7:0]    drop_count,
  output logic          credit_err
);

  localparam int            W          = DATA_PACKET_SIZE;
  localparam int            AW         = $clog2(FIFO_DEPTH);
  localparam logic [RW-1:0] LOCAL_DEST = RW'(LOCAL_RANK);
  localparam logic [7:0]    MAX_OUT    = 8'(MAX_OUTSTANDING);
  localparam logic [AW:0]   DEPTH_CNT  = (AW+1)'(FIFO_DEPTH);

  // Flit field positions, MSB first: dest, resp, seq, payload.
  localparam int DEST_LSB = W - RW;
  localparam int RESP_BIT = W - RW - 1;
  localparam int SEQ_LSB  = PW;

  // Both handshakes stay closed until the first edge after reset releases.
  logic live;

  logic          tx_valid;
  logic [W-1:0]  tx_data;
  logic [3:0]    seq_cnt;
  logic          tx_accept;

  logic [W-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          sink_accept;
  logic          dest_match;
  logic          push;
  logic          pop;
  logic          resp_in;
  logic [W-1:0]  head;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_rtr or posedge reset) begin
    if (reset) live <= 1'b0;
    else       live <= 1'b1;
  end

  // ---------------- TX path ----------------
  assign host_tx_ready = live && (!tx_valid || noc_src.ready) && (outstanding < MAX_OUT);
  assign tx_accept     = host_tx_valid && host_tx_ready;
  assign noc_src.valid = tx_valid;
  assign noc_src.data  = tx_data;

  always_ff @(posedge clk_rtr or posedge reset) begin
    if (reset) begin
      tx_valid <= 1'b0;
      tx_data  <= '0;
      seq_cnt  <= '0;
    end else if (tx_accept) begin
      tx_valid <= 1'b1;
      tx_data  <= {host_tx_dest, 1'b0, seq_cnt, host_tx_payload};
      seq_cnt  <= seq_cnt + 4'd1;
    end else if (noc_src.ready) begin
      tx_valid <= 1'b0;
    end
  end

  // ---------------- RX path ----------------
  assign full           = (count == DEPTH_CNT);
  assign noc_sink.ready = live && !full;
  assign sink_accept    = noc_sink.valid && noc_sink.ready;
  assign dest_match     = (noc_sink.data[DEST_LSB +: RW] == LOCAL_DEST);
  assign push           = sink_accept && dest_match;
  assign resp_in        = push && noc_sink.data[RESP_BIT];
  assign host_rx_valid  = (count != '0);
  assign pop            = host_rx_valid && host_rx_ready;

  // NOTE: the buffer array has no reset; count gates every read, so stale contents are never visible.
  always_ff @(posedge clk_rtr) begin
    if (push) mem[wr_ptr] <= noc_sink.data;
  end

  // Pointers wrap for free because the depth is a power of two.
  always_ff @(posedge clk_rtr or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: defaults come first in combinational blocks so no path leaves an output unassigned (no latch).
  always_comb begin
    head            = '0;
    host_rx_payload = '0;
    host_rx_seq     = '0;
    host_rx_resp    = 1'b0;
    if (host_rx_valid) begin
      head            = mem[rd_ptr];
      host_rx_payload = head[PW-1:0];
      host_rx_seq     = head[SEQ_LSB +: 4];
      host_rx_resp    = head[RESP_BIT];
    end
  end

  // ---------------- Status counters ----------------
  always_ff @(posedge clk_rtr or posedge reset) begin
    if (reset) begin
      drop_count <= '0;
    end else if (sink_accept && !dest_match && (drop_count != 8'hFF)) begin
      drop_count <= drop_count + 8'd1;
    end
  end

  // A response with no credit is still delivered; the counter floors at zero and the error latches.
  always_ff @(posedge clk_rtr or posedge reset) begin
    if (reset) begin
      outstanding <= '0;
      credit_err  <= 1'b0;
    end else begin
      if (tx_accept && !resp_in) begin
        outstanding <= outstanding + 8'd1;
      end else if (resp_in && !tx_accept && (outstanding != 8'd0)) begin
        outstanding <= outstanding - 8'd1;
      end
      if (resp_in && (outstanding == 8'd0)) credit_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_noc_host_endpoint.sv
// Self-checking bench for noc_host_endpoint: directed scenarios plus randomized traffic,
// all compared every cycle against a queue-based behavioural model.
module tb_noc_host_endpoint;

  localparam int W     = 32;
  localparam int RW    = 5;
  localparam int PW    = 22;
  localparam int DEPTH = 4;
  localparam int MAXO  = 8;

  logic          clk_rtr = 1'b0;
  logic          reset;
  logic          host_tx_valid;
  logic          host_tx_ready;
  logic [RW-1:0] host_tx_dest;
  logic [PW-1:0] host_tx_payload;
  logic          host_rx_valid;
  logic          host_rx_ready;
  logic [PW-1:0] host_rx_payload;
  logic [3:0]    host_rx_seq;
  logic          host_rx_resp;
  logic [7:0]    outstanding;
  logic [7:0]    drop_count;
  logic          credit_err;

  bus #(.W(W)) src_if ();
  bus #(.W(W)) sink_if ();

  noc_host_endpoint #(
    .NUM_ROUTER      (20),
    .DATA_PACKET_SIZE(W),
    .LOCAL_RANK      (0),
    .FIFO_DEPTH      (DEPTH),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk_rtr        (clk_rtr),
    .reset          (reset),
    .noc_src        (src_if),
    .noc_sink       (sink_if),
    .host_tx_valid  (host_tx_valid),
    .host_tx_ready  (host_tx_ready),
    .host_tx_dest   (host_tx_dest),
    .host_tx_payload(host_tx_payload),
    .host_rx_valid  (host_rx_valid),
    .host_rx_ready  (host_rx_ready),
    .host_rx_payload(host_rx_payload),
    .host_rx_seq    (host_rx_seq),
    .host_rx_resp   (host_rx_resp),
    .outstanding    (outstanding),
    .drop_count     (drop_count),
    .credit_err     (credit_err)
  );

  always #5 clk_rtr = ~clk_rtr;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- Behavioural model ----------------
  logic         m_alive;
  logic         m_tx_v;
  logic [W-1:0] m_tx_data;
  logic         m_cerr;
  logic         m_sink_fire;
  int           m_seq;
  int           m_out;
  int           m_drop;
  logic [W-1:0] m_q[$];

  function automatic logic m_tx_ready();
    return m_alive && (!m_tx_v || src_if.ready) && (m_out < MAXO);
  endfunction

  function automatic logic m_sink_ready();
    return m_alive && (m_q.size() < DEPTH);
  endfunction

  task automatic m_clear();
    m_alive = 1'b0; m_tx_v = 1'b0; m_tx_data = '0; m_cerr = 1'b0; m_sink_fire = 1'b0;
    m_seq = 0; m_out = 0; m_drop = 0;
    m_q.delete();
  endtask

  task automatic m_step();
    logic tx_acc, sink_acc, pop, match, rsp;
    tx_acc   = host_tx_valid && m_tx_ready();
    sink_acc = sink_if.valid && m_sink_ready();
    pop      = (m_q.size() != 0) && host_rx_ready;
    match    = sink_acc && (sink_if.data[31:27] == 5'd0);
    rsp      = match && sink_if.data[26];
    m_sink_fire = sink_acc;
    if (m_tx_v && src_if.ready) m_tx_v = 1'b0;
    if (tx_acc) begin
      m_tx_v    = 1'b1;
      m_tx_data = {host_tx_dest, 1'b0, 4'(m_seq), host_tx_payload};
      m_seq     = (m_seq + 1) % 16;
    end
    if (pop) void'(m_q.pop_front());
    if (match) m_q.push_back(sink_if.data);
    if (sink_acc && !match && m_drop < 255) m_drop++;
    if (rsp && m_out == 0) m_cerr = 1'b1;
    m_out = m_out + int'(tx_acc) - int'(rsp);
    if (m_out < 0) m_out = 0;
    m_alive = 1'b1;
  endtask

  initial begin
    m_clear();
    forever begin
      @(posedge clk_rtr or posedge reset);
      if (reset) m_clear();
      else       m_step();
    end
  end

  // ---------------- Compare process ----------------
  initial begin
    logic [W-1:0] f;
    forever begin
      @(negedge clk_rtr);
      check("src_valid", src_if.valid, m_tx_v);
      if (m_tx_v) check("src_data", src_if.data, m_tx_data);
      check("sink_ready", sink_if.ready, m_sink_ready());
      check("tx_ready", host_tx_ready, m_tx_ready());
      check("rx_valid", host_rx_valid, m_q.size() != 0);
      if (m_q.size() != 0) begin
        f = m_q[0];
        check("rx_payload", host_rx_payload, f[21:0]);
        check("rx_seq", host_rx_seq, f[25:22]);
        check("rx_resp", host_rx_resp, f[26]);
      end
      check("outstanding", outstanding, m_out);
      check("drop_count", drop_count, m_drop);
      check("credit_err", credit_err, m_cerr);
    end
  end

  // ---------------- Stimulus helpers ----------------
  task automatic step();
    @(posedge clk_rtr);
    #1;
  endtask

  task automatic tx_send(input logic [RW-1:0] d, input logic [PW-1:0] p);
    logic done = 1'b0;
    host_tx_dest = d; host_tx_payload = p; host_tx_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk_rtr);
      done = host_tx_ready;
      step();
    end
    host_tx_valid = 1'b0;
    check("tx_accept", done, 1);
  endtask

  task automatic rtr_send(input logic [RW-1:0] d, input logic r, input logic [3:0] s,
                          input logic [PW-1:0] p);
    logic done = 1'b0;
    sink_if.data = {d, r, s, p}; sink_if.valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk_rtr);
      done = sink_if.ready;
      step();
    end
    sink_if.valid = 1'b0;
    check("rx_accept", done, 1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_src_valid"}, src_if.valid, 0);
    check({tag, "_src_data"}, src_if.data, 0);
    check({tag, "_sink_ready"}, sink_if.ready, 0);
    check({tag, "_tx_ready"}, host_tx_ready, 0);
    check({tag, "_rx_valid"}, host_rx_valid, 0);
    check({tag, "_rx_payload"}, host_rx_payload, 0);
    check({tag, "_rx_seq"}, host_rx_seq, 0);
    check({tag, "_rx_resp"}, host_rx_resp, 0);
    check({tag, "_outstanding"}, outstanding, 0);
    check({tag, "_drop"}, drop_count, 0);
    check({tag, "_credit_err"}, credit_err, 0);
  endtask

  // ---------------- Main sequence ----------------
  initial begin
    logic [W-1:0]  d;
    logic          held;
    logic [RW-1:0] rd;

    reset = 1'b1;
    host_tx_valid = 1'b0; host_tx_dest = '0; host_tx_payload = '0; host_rx_ready = 1'b0;
    src_if.ready = 1'b1; sink_if.valid = 1'b0; sink_if.data = '0;

    #3;
    check_reset_values("por");
    @(posedge clk_rtr); @(posedge clk_rtr); #1;
    reset = 1'b0;
    check("pre_edge_sink_ready", sink_if.ready, 0);
    step();
    check("post_edge_sink_ready", sink_if.ready, 1);
    check("post_edge_tx_ready", host_tx_ready, 1);

    // First request: exact flit image and credit.
    tx_send(5'd7, 22'h155AA);
    check("t1_src_valid", src_if.valid, 1);
    check("t1_src_data", src_if.data, 32'h380155AA);
    check("t1_outstanding", outstanding, 1);

    // Fill the credit window, then hold a request that must stall.
    for (int i = 1; i < 8; i++) tx_send(RW'(i), PW'($urandom));
    d = src_if.data;
    check("seq_7", d[25:22], 7);
    check("credit_full_out", outstanding, 8);
    host_tx_valid = 1'b1;
    step(); step(); step();
    check("credit_full_ready", host_tx_ready, 0);
    check("credit_hold_out", outstanding, 8);
    host_tx_valid = 1'b0;

    // Four responses fill the RX buffer; the fifth waits upstream.
    for (int i = 0; i < 4; i++) rtr_send(5'd0, 1'b1, 4'(i), PW'(32'h100 + i));
    check("fifo_full_ready", sink_if.ready, 0);
    check("fifo_full_out", outstanding, 4);
    sink_if.data = {5'd0, 1'b1, 4'd4, 22'h104}; sink_if.valid = 1'b1;
    step(); step(); step();
    check("fifth_held_ready", sink_if.ready, 0);
    check("head_payload", host_rx_payload, 32'h100);
    host_rx_ready = 1'b1;
    held = 1'b0;
    for (int i = 0; i < 20 && !held; i++) begin
      @(negedge clk_rtr);
      held = sink_if.ready;
      step();
    end
    sink_if.valid = 1'b0;
    check("fifth_accepted", held, 1);
    check("after_fifth_out", outstanding, 3);
    for (int i = 0; i < 3; i++) rtr_send(5'd0, 1'b1, 4'(i), PW'($urandom));
    check("credit_returned", outstanding, 0);

    // Sequence tags 8..15, then wrap to 0.
    for (int i = 8; i < 16; i++) tx_send(RW'(i), PW'($urandom));
    d = src_if.data;
    check("seq_15", d[25:22], 15);
    for (int i = 0; i < 8; i++) rtr_send(5'd0, 1'b1, 4'(i), PW'($urandom));
    tx_send(5'd4, 22'h0ABCD);
    d = src_if.data;
    check("seq_wrap", d[25:22], 0);
    check("wrap_out", outstanding, 1);
    rtr_send(5'd0, 1'b1, 4'd0, 22'h0ABCD);

    // Misrouted flits are dropped and counted with saturation.
    rtr_send(5'd3, 1'b0, 4'd1, 22'h3);
    check("drop_one", drop_count, 1);
    check("drop_no_rx", host_rx_valid, 0);
    for (int i = 0; i < 299; i++) begin
      rd = RW'($urandom_range(1, 19));
      rtr_send(rd, 1'($urandom_range(0, 1)), 4'($urandom), PW'($urandom));
    end
    check("drop_sat", drop_count, 255);

    // Response with no credit outstanding.
    host_rx_ready = 1'b0;
    rtr_send(5'd0, 1'b1, 4'd5, 22'h3AB);
    check("nocredit_rx_valid", host_rx_valid, 1);
    check("nocredit_resp", host_rx_resp, 1);
    check("nocredit_payload", host_rx_payload, 32'h3AB);
    check("nocredit_out", outstanding, 0);
    check("nocredit_err", credit_err, 1);
    host_rx_ready = 1'b1;
    step(); step();

    // Simultaneous request and response leave the count unchanged.
    tx_send(5'd2, 22'h11);
    check("simul_pre_out", outstanding, 1);
    host_tx_dest = 5'd6; host_tx_payload = 22'h22; host_tx_valid = 1'b1;
    sink_if.data = {5'd0, 1'b1, 4'd9, 22'h33}; sink_if.valid = 1'b1;
    step();
    host_tx_valid = 1'b0; sink_if.valid = 1'b0;
    check("simul_out", outstanding, 1);
    step(); step();

    // Reset with two buffered flits and a pending TX flit.
    src_if.ready = 1'b0; host_rx_ready = 1'b0;
    tx_send(5'd9, 22'h2222);
    rtr_send(5'd0, 1'b0, 4'd1, 22'h1);
    rtr_send(5'd0, 1'b0, 4'd2, 22'h2);
    check("pre_rst_src_valid", src_if.valid, 1);
    check("pre_rst_rx_valid", host_rx_valid, 1);
    #3;
    reset = 1'b1;
    #1;
    check_reset_values("midrst");
    @(posedge clk_rtr); @(posedge clk_rtr); #1;
    reset = 1'b0;
    check("rel_sink_ready", sink_if.ready, 0);
    step();
    check("rel_edge_sink_ready", sink_if.ready, 1);
    check("rel_edge_tx_ready", host_tx_ready, 1);

    // Randomized traffic, with one asynchronous reset in the middle.
    for (int c = 0; c < 2000; c++) begin
      src_if.ready    = ($urandom_range(0, 3) != 0);
      host_rx_ready   = ($urandom_range(0, 3) != 0);
      host_tx_valid   = 1'($urandom_range(0, 1));
      host_tx_dest    = RW'($urandom_range(0, 19));
      host_tx_payload = PW'($urandom);
      if (!sink_if.valid || m_sink_fire) begin
        rd = ($urandom_range(0, 2) == 0) ? RW'($urandom_range(1, 19)) : 5'd0;
        sink_if.valid = 1'($urandom_range(0, 1));
        sink_if.data  = {rd, 1'($urandom_range(0, 1)), 4'($urandom), PW'($urandom)};
      end
      if (c == 1000) begin
        #3;
        reset = 1'b1;
        sink_if.valid = 1'b0; host_tx_valid = 1'b0;
        #1;
        check("rand_rst_src_valid", src_if.valid, 0);
        check("rand_rst_outstanding", outstanding, 0);
        step(); step();
        reset = 1'b0;
      end
      step();
    end
    host_tx_valid = 1'b0; sink_if.valid = 1'b0; host_rx_ready = 1'b1; src_if.ready = 1'b1;
    repeat (8) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/noc_host_endpoint.md
# noc_host_endpoint

Host-side network interface for the router chain. It attaches to the east port of the rank-0 router, the port that faces the PCI interface. It turns host requests into single-flit NoC packets with a routing header and a sequence tag, and injects them toward a destination rank. It also buffers flits returned by the router, filters them, and hands them to the host while tracking outstanding requests.

## Interface
Parameters:
- NUM_ROUTER, 20: routers in the chain. RW = $clog2(NUM_ROUTER) is the rank field width.
- DATA_PACKET_SIZE, 32: flit width W.
- LOCAL_RANK, 0: rank this endpoint is attached to.
- FIFO_DEPTH, 4: RX buffer entries, power of two, ≥2.
- MAX_OUTSTANDING, 8: request credit limit, ≤255.

Ports:
- clk_rtr  in  1  single clock for the whole block.
- reset  in  1  asynchronous, active-high.
- noc_src  bus.source  valid/ready/data(W)  flits toward the router east sink.
- noc_sink  bus.sink  valid/ready/data(W)  flits from the router east source.
- host_tx_valid  in  1  host request valid.
- host_tx_ready  out  1  request accepted when valid&&ready.
- host_tx_dest  in  RW  destination rank.
- host_tx_payload  in  PW  payload, PW = W-RW-5 (22 at defaults).
- host_rx_valid  out  1  delivered flit valid.
- host_rx_ready  in  1  host accepts the delivered flit.
- host_rx_payload  out  PW  delivered payload.
- host_rx_seq  out  4  delivered sequence tag.
- host_rx_resp  out  1  delivered response flag.
- outstanding  out  8  requests in flight.
- drop_count  out  8  misrouted flits discarded, saturating.
- credit_err  out  1  sticky: a response arrived with outstanding==0.

## Operation
- Flit format, MSB first: dest[RW], resp[1], seq[4], payload[PW].
- Bus rule: a transfer happens on a cycle where valid&&ready. A source holds valid and data stable until the transfer completes.
- TX path: one-entry output register.
  - host_tx_ready = (!noc_src.valid || noc_src.ready) && (outstanding < MAX_OUTSTANDING).
  - On accept, the register loads {host_tx_dest, 1'b0, seq_cnt, payload}, and seq_cnt increments modulo 16 (15→0).
- RX path: FIFO_DEPTH-entry FIFO with a pointer and count.
  - noc_sink.ready = !full.
  - On an accepted flit whose dest == LOCAL_RANK, the flit is written to the FIFO.
  - On an accepted flit whose dest ≠ LOCAL_RANK, the flit is discarded and drop_count increments, saturating at 255.
  - The FIFO head drives host_rx_*. The head pops when host_rx_valid&&host_rx_ready.
- Outstanding counter:
  - +1 on a TX accept.
  - −1 on an RX accept of a matching flit with resp=1.
  - A simultaneous +1 and −1 leave it unchanged.
  - A response arriving with outstanding==0 is still delivered; the counter stays at 0 and credit_err sets until reset.
- FIFO full: ready stays low and the upstream router holds its flit. A push and a pop in the same cycle when full is not possible because ready is 0 when full.
- FIFO simultaneous push and pop when neither full nor empty: the count is unchanged.
- Reset (asynchronous, at any time, including mid-transfer):
  - All state clears and any in-flight flit in either path is lost.
  - Reset values: noc_src.valid=0, noc_src.data=0, noc_sink.ready=0, host_tx_ready=0, host_rx_valid=0, host_rx_payload/seq/resp=0, outstanding=0, drop_count=0, credit_err=0, seq_cnt=0.
  - After reset deasserts, noc_sink.ready=1 and host_tx_ready=1 on the first clock edge.

## Timing
- TX latency: host accept at edge N; noc_src.valid is high after edge N, so the flit can transfer in cycle N+1.
- TX throughput: back-to-back, one flit per cycle while noc_src.ready=1 and credit remains.
- RX latency: flit accepted at edge N; host_rx_valid is high after edge N. There is no combinational path from noc_sink.valid to host_rx_valid.
- RX throughput: one flit per cycle.
- Registered outputs: outstanding, drop_count and credit_err update on the same edge as the event that changes them.
- Combinational outputs: host_tx_ready and noc_sink.ready are combinational from registered state plus noc_src.ready.

## Test plan
- TX to rank 7, payload 0x155AA, noc_src.ready=1 -> noc_src.data = {5'd7, 1'b0, 4'd0, 22'h155AA} one cycle after accept; outstanding=1.
- 17 back-to-back requests -> seq tags 0..15 then 0 (wrap). With MAX_OUTSTANDING=8 and no responses, host_tx_ready drops after the 8th accept and outstanding holds at 8.
- 5 matching responses with host_rx_ready=0 and FIFO_DEPTH=4 -> noc_sink.ready=0 after the 4th flit and the 5th is held upstream. Setting host_rx_ready=1 drains the flits in order and the 5th is accepted.
- RX flit with dest=3 -> discarded, host_rx_valid stays 0, drop_count=1. 300 such flits -> drop_count=255.
- Response when outstanding=0 -> the flit is delivered, outstanding=0 and credit_err=1. A TX accept and a response accept in the same cycle -> outstanding unchanged.
- Assert reset with 2 flits buffered and a TX flit pending -> every output returns to its reset value immediately, and noc_sink.ready=1 on the first edge after release.
